systolic_array: RTL and testbench

- Output-stationary N x N signed MAC array directly downstream of the input loader.
- Consumes the loader's skewed row stream (x), column stream (y) and its one-cycle init pulse, and accumulates Z = X * Y over K inner-product terms.
- Holds the finished N*N results for the result readout stage, with a one-cycle done pulse and a busy level.
- Edge validity is generated internally from init, so stale loader outputs never enter the array.

---
 rtl/systolic_array.sv | 144 ++++++++++++++
 tb/tb_systolic_array.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array.sv
// Output-stationary N x N signed MAC array fed by the loader's skewed row/column stream.
// Edge operands are gated from an internal cycle counter so only in-window words reach the PEs.
module systolic_array #(
  parameter int D_W    = 8,
  parameter int N      = 2,
  parameter int K      = 2,
  parameter int ACC_W  = 20,
  parameter int IN_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [N*D_W-1:0]     in_x_flat,
  input  logic [N*D_W-1:0]     in_y_flat,
  output logic [N*N*ACC_W-1:0] out_z_flat,
  output logic                 busy,
  output logic                 done
);

  localparam int C_END = IN_LAT + 2*(N-1) + K + 1;
  localparam int CW    = $clog2(IN_LAT + K + 2*N) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] c_q;
  logic [CW-1:0] c_step;
  logic          busy_q;
  logic          done_q;
  logic          step;

  // A normal accumulate edge; an init edge instead clears everything.
  assign step   = (state_q == ST_RUN) && !init;
  assign c_step = c_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (init) begin
            state_q <= ST_RUN;
            c_q     <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (init) begin
            c_q    <= '0;
            busy_q <= 1'b0;
          end else if (c_step == CW'(C_END)) begin
            state_q <= ST_DONE;
            c_q     <= c_step;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            c_q    <= c_step;
            busy_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (init) begin
            state_q <= ST_RUN;
            c_q     <= '0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // x_in[i][j] / y_in[i][j] is the operand presented to PE(i,j) this cycle.
  logic [N-1:0]          x_gate;
  logic [N-1:0]          y_gate;
  logic signed [D_W-1:0] x_in [N][N];
  logic signed [D_W-1:0] y_in [N][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign x_gate[gi] = step && (c_step >= CW'(IN_LAT + gi)) && (c_step <= CW'(IN_LAT + gi + K - 1));
    assign y_gate[gi] = step && (c_step >= CW'(IN_LAT + gi)) && (c_step <= CW'(IN_LAT + gi + K - 1));
    assign x_in[gi][0] = x_gate[gi] ? in_x_flat[(gi+1)*D_W-1 -: D_W] : '0;
    assign y_in[0][gi] = y_gate[gi] ? in_y_flat[(gi+1)*D_W-1 -: D_W] : '0;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [D_W-1:0]   x_q;
      logic signed [D_W-1:0]   y_q;
      logic signed [ACC_W-1:0] acc_q;
      logic signed [ACC_W-1:0] acc_d;
      logic signed [ACC_W-1:0] x_ext;
      logic signed [ACC_W-1:0] y_ext;

      // Multiplying sign-extended operands at ACC_W gives the wrapped signed product directly.
      assign x_ext = {{(ACC_W-D_W){x_q[D_W-1]}}, x_q};
      assign y_ext = {{(ACC_W-D_W){y_q[D_W-1]}}, y_q};

      always_comb begin
        acc_d = acc_q;
        if (init) begin
          acc_d = '0;
        end else if (step) begin
          acc_d = acc_q + x_ext * y_ext;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          x_q   <= '0;
          y_q   <= '0;
          acc_q <= '0;
        end else begin
          x_q   <= step ? x_in[gi][gj] : '0;
          y_q   <= step ? y_in[gi][gj] : '0;
          acc_q <= acc_d;
        end
      end

      if (gj < N-1) begin : g_xfwd
        assign x_in[gi][gj+1] = x_q;
      end
      if (gi < N-1) begin : g_yfwd
        assign y_in[gi+1][gj] = y_q;
      end

      assign out_z_flat[(gi*N+gj+1)*ACC_W-1 -: ACC_W] = acc_q;
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Randomised bench for systolic_array: streams X/Y per the loader skew contract and
// compares results and busy/done timing with a plain matrix-product model.
module tb_systolic_array;

  localparam int D_W    = 8;
  localparam int N      = 2;
  localparam int K      = 2;
  localparam int ACC_W  = 20;
  localparam int IN_LAT = 1;
  localparam int XW     = N*D_W;
  localparam int ZW     = N*N*ACC_W;
  localparam int C_END  = IN_LAT + 2*(N-1) + K + 1;
  localparam int VW     = C_END + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init = 1'b0;
  logic [XW-1:0] in_x_flat = '0;
  logic [XW-1:0] in_y_flat = '0;
  logic [ZW-1:0] out_z_flat;
  logic          busy;
  logic          done;

  systolic_array #(
    .D_W(D_W), .N(N), .K(K), .ACC_W(ACC_W), .IN_LAT(IN_LAT)
  ) dut (
    .clk(clk), .rst(rst), .init(init),
    .in_x_flat(in_x_flat), .in_y_flat(in_y_flat),
    .out_z_flat(out_z_flat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int mx [N][K];
  int my [K][N];
  int garb_mode = 0;

  logic [VW-1:0] exp_busy_v;
  logic [VW-1:0] exp_done_v;
  logic [VW-1:0] obs_busy;
  logic [VW-1:0] obs_done;
  logic [ZW-1:0] z_at_done;
  logic [ZW-1:0] z_after;

  function automatic logic [D_W-1:0] garbage_word();
    if (garb_mode == 1) return '1;
    return D_W'($urandom);
  endfunction

  function automatic logic [ZW-1:0] model_z();
    logic [ZW-1:0] z;
    int s;
    z = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < K; k++) s += mx[i][k] * my[k][j];
        z[(i*N+j+1)*ACC_W-1 -: ACC_W] = ACC_W'(s);
      end
    end
    return z;
  endfunction

  task automatic randomize_mats();
    for (int a = 0; a < N; a++)
      for (int b = 0; b < K; b++) begin
        mx[a][b] = int'($urandom_range(255)) - 128;
        my[b][a] = int'($urandom_range(255)) - 128;
      end
  endtask

  // Row r word k and column c word k are presented for edge IN_LAT+r+k / IN_LAT+c+k.
  task automatic drive_inputs(input int e);
    int k;
    for (int r = 0; r < N; r++) begin
      k = e - IN_LAT - r;
      if (k >= 0 && k < K) in_x_flat[(r+1)*D_W-1 -: D_W] = D_W'(mx[r][k]);
      else                 in_x_flat[(r+1)*D_W-1 -: D_W] = garbage_word();
      if (k >= 0 && k < K) in_y_flat[(r+1)*D_W-1 -: D_W] = D_W'(my[k][r]);
      else                 in_y_flat[(r+1)*D_W-1 -: D_W] = garbage_word();
    end
  endtask

  // Starts at a negedge; pulses init, streams one run and records busy/done per cycle c.
  // Returns at the negedge of cycle stop_at (or after cycle C_END+1 when stop_at < 0).
  task automatic do_run(input int stop_at);
    obs_busy  = '0;
    obs_done  = '0;
    z_at_done = '0;
    z_after   = '0;
    init = 1'b1;
    drive_inputs(0);
    @(posedge clk);
    for (int c = 0; c <= C_END + 1; c++) begin
      @(negedge clk);
      obs_busy[c] = busy;
      obs_done[c] = done;
      if (c == C_END)     z_at_done = out_z_flat;
      if (c == C_END + 1) z_after   = out_z_flat;
      init = 1'b0;
      drive_inputs(c + 1);
      if (c == stop_at) return;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    init = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_z_flat !== '0) begin n_fail++; $display("FAIL reset_z got %h expected 0", out_z_flat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_x_flat = XW'($urandom);
      in_y_flat = XW'($urandom);
      @(negedge clk);
      n_checks++; if (out_z_flat !== '0) begin n_fail++; $display("FAIL idle_z cyc %0d got %h expected 0", i, out_z_flat); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy cyc %0d got %b expected 0", i, busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL idle_done cyc %0d got %b expected 0", i, done); end
    end
    $display("reset/idle: z=%h busy=%b done=%b", out_z_flat, busy, done);
  endtask

  task automatic test_basic();
    garb_mode = 0;
    mx = '{'{1, 2}, '{3, 4}};
    my = '{'{5, 6}, '{7, 8}};
    do_run(-1);
    $display("basic: z=%h busy=%b done=%b", z_at_done, obs_busy, obs_done);
    n_checks++; if (obs_busy !== exp_busy_v) begin n_fail++; $display("FAIL basic_busy got %b expected %b", obs_busy, exp_busy_v); end
    n_checks++; if (obs_done !== exp_done_v) begin n_fail++; $display("FAIL basic_done got %b expected %b", obs_done, exp_done_v); end
    n_checks++; if (z_at_done[ACC_W-1:0] !== 20'd19) begin n_fail++; $display("FAIL basic_z00 got %0d expected 19", z_at_done[ACC_W-1:0]); end
    n_checks++; if (z_at_done !== model_z()) begin n_fail++; $display("FAIL basic_z got %h expected %h", z_at_done, model_z()); end
    n_checks++; if (z_after !== model_z()) begin n_fail++; $display("FAIL basic_hold got %h expected %h", z_after, model_z()); end
  endtask

  task automatic test_signed();
    garb_mode = 0;
    mx = '{'{-128, -128}, '{1, -1}};
    my = '{'{-128, 0}, '{-128, 1}};
    do_run(-1);
    $display("signed: z=%h busy=%b done=%b", z_at_done, obs_busy, obs_done);
    n_checks++; if (obs_done !== exp_done_v) begin n_fail++; $display("FAIL signed_done got %b expected %b", obs_done, exp_done_v); end
    n_checks++; if (z_at_done !== model_z()) begin n_fail++; $display("FAIL signed_z got %h expected %h", z_at_done, model_z()); end
  endtask

  task automatic test_garbage();
    garb_mode = 1;
    mx = '{'{1, 0}, '{0, 1}};
    my = '{'{9, 8}, '{7, 6}};
    do_run(-1);
    $display("garbage: z=%h busy=%b done=%b", z_at_done, obs_busy, obs_done);
    n_checks++; if (z_at_done !== model_z()) begin n_fail++; $display("FAIL garbage_z got %h expected %h", z_at_done, model_z()); end
    n_checks++; if (obs_busy !== exp_busy_v) begin n_fail++; $display("FAIL garbage_busy got %b expected %b", obs_busy, exp_busy_v); end
    garb_mode = 0;
  endtask

  task automatic test_restart();
    logic [VW-1:0] m;
    randomize_mats();
    do_run(3);
    m = '0;
    for (int c = 0; c <= 3; c++) m[c] = 1'b1;
    n_checks++; if ((obs_busy & m) !== (exp_busy_v & m)) begin n_fail++; $display("FAIL restart_first_busy got %b expected %b", obs_busy & m, exp_busy_v & m); end
    mx = '{'{1, 2}, '{3, 4}};
    my = '{'{5, 6}, '{7, 8}};
    do_run(-1);
    $display("restart: z=%h busy=%b done=%b", z_at_done, obs_busy, obs_done);
    n_checks++; if (obs_done !== exp_done_v) begin n_fail++; $display("FAIL restart_done got %b expected %b", obs_done, exp_done_v); end
    n_checks++; if (obs_busy !== exp_busy_v) begin n_fail++; $display("FAIL restart_busy got %b expected %b", obs_busy, exp_busy_v); end
    n_checks++; if (z_at_done !== model_z()) begin n_fail++; $display("FAIL restart_z got %h expected %h", z_at_done, model_z()); end
  endtask

  task automatic test_async_reset();
    randomize_mats();
    do_run(4);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out_z_flat !== '0) begin n_fail++; $display("FAIL arst_z got %h expected 0", out_z_flat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b expected 0", done); end
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_quiet cyc %0d got busy=%b done=%b expected 0/0", i, busy, done); end
    end
    randomize_mats();
    do_run(-1);
    $display("after async reset: z=%h busy=%b done=%b", z_at_done, obs_busy, obs_done);
    n_checks++; if (obs_done !== exp_done_v) begin n_fail++; $display("FAIL arst_rerun_done got %b expected %b", obs_done, exp_done_v); end
    n_checks++; if (z_at_done !== model_z()) begin n_fail++; $display("FAIL arst_rerun_z got %h expected %h", z_at_done, model_z()); end
  endtask

  task automatic test_init_held();
    init = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL held_init cyc %0d got busy=%b done=%b expected 0/0", i, busy, done); end
    end
    randomize_mats();
    do_run(-1);
    $display("init held: z=%h busy=%b done=%b", z_at_done, obs_busy, obs_done);
    n_checks++; if (obs_done !== exp_done_v) begin n_fail++; $display("FAIL held_done got %b expected %b", obs_done, exp_done_v); end
    n_checks++; if (z_at_done !== model_z()) begin n_fail++; $display("FAIL held_z got %h expected %h", z_at_done, model_z()); end
  endtask

  // Chained runs: each next init is raised in the previous run's done cycle.
  task automatic test_back_to_back();
    logic [VW-1:0] m;
    for (int r = 0; r < 5; r++) begin
      garb_mode = r % 2;
      randomize_mats();
      do_run(r < 4 ? C_END : -1);
      m = '1;
      if (r < 4) m[C_END+1] = 1'b0;
      $display("b2b run %0d: z=%h busy=%b done=%b", r, z_at_done, obs_busy, obs_done);
      n_checks++; if ((obs_busy & m) !== (exp_busy_v & m)) begin n_fail++; $display("FAIL b2b_busy run %0d got %b expected %b", r, obs_busy & m, exp_busy_v & m); end
      n_checks++; if ((obs_done & m) !== (exp_done_v & m)) begin n_fail++; $display("FAIL b2b_done run %0d got %b expected %b", r, obs_done & m, exp_done_v & m); end
      n_checks++; if (z_at_done !== model_z()) begin n_fail++; $display("FAIL b2b_z run %0d got %h expected %h", r, z_at_done, model_z()); end
    end
    garb_mode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < VW; c++) begin
      exp_busy_v[c] = (c >= 1 && c <= C_END - 1);
      exp_done_v[c] = (c == C_END);
    end
    test_reset();
    test_basic();
    test_signed();
    test_garbage();
    test_restart();
    test_async_reset();
    test_init_held();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
